// File: rtl/fuzz_sig_monitor_if.sv
// Handshake bundle between a fuzz harness and its MISR response compactor.
// The harness side drives the run controls and DUT samples; the monitor reports status.
interface fuzz_sig_monitor_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] expected;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CW-1:0]    count;

  modport master (
    output start, seed, in_valid, in_data, expected,
    input  busy, done, pass, signature, count
  );

  modport slave (
    input  start, seed, in_valid, in_data, expected,
    output busy, done, pass, signature, count
  );
endinterface

// File: rtl/fuzz_sig_monitor.sv
// MISR response compactor: folds CYCLES valid DUT words into a signature,
// then holds it with a pass flag against a golden value.
module fuzz_sig_monitor #(
  parameter int               WIDTH  = 32,
  parameter int               CYCLES = 20,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(32'h04C1_1DB7),
  parameter int               CW     = $clog2(CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fuzz_sig_monitor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sig_q, sig_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;

  // One MISR step: shift left, fold the dropped MSB back through POLY, xor the sample.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = {s[WIDTH-2:0], 1'b0} ^ d;
    if (s[WIDTH-1]) r = r ^ POLY;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      sig_q <= sig_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // start wins over in_valid in every state; a coincident sample is dropped.
  always_comb begin
    state_nxt = state;
    sig_nxt   = sig_q;
    cnt_nxt   = cnt_q;
    if (bus.start) begin
      state_nxt = RUN;
      sig_nxt   = bus.seed;
      cnt_nxt   = '0;
    end else if (state == RUN && bus.in_valid) begin
      sig_nxt = misr_step(sig_q, bus.in_data);
      cnt_nxt = cnt_q + CW'(1);
      if (cnt_q == CW'(CYCLES - 1)) state_nxt = DONE;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.signature = sig_q;
  assign bus.count     = cnt_q;
  assign bus.pass      = (state == DONE) && (sig_q == bus.expected);

endmodule

// File: tb/tb_fuzz_sig_monitor.sv
// Bench for fuzz_sig_monitor: directed vector table, async reset and default-parameter
// sequences, and randomized runs against a polynomial-arithmetic reference model.
module tb_fuzz_sig_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuzz_sig_monitor_if #(.WIDTH(8),  .CW(2)) sbus ();
  fuzz_sig_monitor_if #(.WIDTH(32), .CW(5)) bbus ();

  fuzz_sig_monitor #(.WIDTH(8), .CYCLES(3), .POLY(8'h1D)) dut_s (
    .clk(clk), .rst(rst), .bus(sbus.slave)
  );
  fuzz_sig_monitor dut_b (
    .clk(clk), .rst(rst), .bus(bbus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Signature as a GF(2) polynomial: multiply by x modulo (x^W + poly), then add the sample.
  function automatic longint unsigned ref_step(input longint unsigned s, input longint unsigned d,
                                               input int w, input longint unsigned poly);
    longint unsigned full, t;
    full = (64'd1 << w) | poly;
    t = s << 1;
    if (t[w]) t = t ^ full;
    return t ^ d;
  endfunction

  typedef struct {
    logic       start;
    logic [7:0] seed;
    logic       valid;
    logic [7:0] data;
    logic [7:0] expected;
    logic [7:0] e_sig;
    int         e_cnt;
    logic       e_busy;
    logic       e_done;
    logic       e_pass;
  } vec_t;

  vec_t vecs[$];

  task automatic s_check(input string tag, input logic [7:0] sig, input int cnt,
                         input logic busy, input logic done, input logic pass);
    chk({tag, ".sig"},  32'(sbus.signature), 32'(sig));
    chk({tag, ".cnt"},  32'(sbus.count),     32'(cnt));
    chk({tag, ".busy"}, 32'(sbus.busy),      32'(busy));
    chk({tag, ".done"}, 32'(sbus.done),      32'(done));
    chk({tag, ".pass"}, 32'(sbus.pass),      32'(pass));
  endtask

  task automatic s_drive(input logic st, input logic [7:0] sd, input logic v,
                         input logic [7:0] d, input logic [7:0] ex);
    sbus.start = st; sbus.seed = sd; sbus.in_valid = v; sbus.in_data = d; sbus.expected = ex;
  endtask

  task automatic b_drive(input logic st, input logic [31:0] sd, input logic v, input logic [31:0] d);
    bbus.start = st; bbus.seed = sd; bbus.in_valid = v; bbus.in_data = d; bbus.expected = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rdata[20];
    logic [31:0] seed_b, sig_a;
    longint unsigned m;
    int          m_mode, m_cnt;
    logic [7:0]  m_sig;
    logic        st, v;
    logic [7:0]  sd, d, ex;

    s_drive(0, 8'h00, 0, 8'h00, 8'h00);
    b_drive(0, '0, 0, '0);
    tick();
    tick();
    s_check("reset", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // start, valid, data, expected -> sig, count, busy, done, pass
    // pure shift, then expected change while DONE
    vecs.push_back('{1, 8'h01, 0, 8'h00, 8'h08, 8'h01, 0, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h02, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h04, 2, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h08, 3, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 8'h09, 8'h08, 3, 0, 1, 0});
    // feedback: 80 -> 1D -> (3A^FF)=C5 -> (8A^1D^00)=97
    vecs.push_back('{1, 8'h80, 0, 8'h00, 8'h97, 8'h80, 0, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h97, 8'h1D, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'hFF, 8'h97, 8'hC5, 2, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h97, 8'h97, 3, 0, 1, 1});
    // gaps in in_valid, then ignored samples while DONE
    vecs.push_back('{1, 8'h01, 0, 8'h00, 8'h08, 8'h01, 0, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h02, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 8'hAA, 8'h08, 8'h02, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 8'h55, 8'h08, 8'h02, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h04, 2, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h08, 8'h08, 3, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hFF, 8'h08, 8'h08, 3, 0, 1, 1});
    // restart mid-run with a coincident sample that must be dropped
    vecs.push_back('{1, 8'h01, 0, 8'h00, 8'h3A, 8'h01, 0, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h3A, 8'h02, 1, 1, 0, 0});
    vecs.push_back('{1, 8'h40, 1, 8'hFF, 8'h3A, 8'h40, 0, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h3A, 8'h80, 1, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h3A, 8'h1D, 2, 1, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 8'h00, 8'h3A, 8'h3A, 3, 0, 1, 1});

    foreach (vecs[i]) begin
      s_drive(vecs[i].start, vecs[i].seed, vecs[i].valid, vecs[i].data, vecs[i].expected);
      tick();
      s_check($sformatf("vec%0d", i), vecs[i].e_sig, vecs[i].e_cnt,
              vecs[i].e_busy, vecs[i].e_done, vecs[i].e_pass);
    end

    // asynchronous reset in the middle of a run
    s_drive(1, 8'h5A, 0, 8'h00, 8'h00);
    tick();
    s_drive(0, 8'h00, 1, 8'h33, 8'h00);
    tick();
    chk("pre_rst.cnt", 32'(sbus.count), 32'd1);
    #2 rst = 1'b1;
    #1;
    s_check("async_rst", 8'h00, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    s_drive(0, 8'h00, 1, 8'h77, 8'h00);
    tick();
    tick();
    s_check("post_rst_idle", 8'h00, 0, 0, 0, 0);

    // default parameters: zero seed and zero data for exactly CYCLES samples
    b_drive(1, '0, 0, '0);
    tick();
    b_drive(0, '0, 1, '0);
    for (int i = 0; i < 19; i++) tick();
    chk("big.not_done_19", 32'(bbus.done), 32'd0);
    chk("big.cnt_19", 32'(bbus.count), 32'd19);
    tick();
    chk("big.done_20", 32'(bbus.done), 32'd1);
    chk("big.sig_zero", bbus.signature, 32'd0);
    tick();
    chk("big.frozen_cnt", 32'(bbus.count), 32'd20);

    // repeatability: same seed and data twice, compared to each other and to the model
    seed_b = $urandom;
    foreach (rdata[i]) rdata[i] = $urandom;
    m = 64'(seed_b);
    foreach (rdata[i]) m = ref_step(m, 64'(rdata[i]), 32, 64'h04C1_1DB7);
    sig_a = '0;
    for (int rep = 0; rep < 2; rep++) begin
      b_drive(1, seed_b, 0, '0);
      tick();
      for (int i = 0; i < 20; i++) begin
        b_drive(0, '0, 1, rdata[i]);
        tick();
      end
      b_drive(0, '0, 0, '0);
      chk($sformatf("big.rand_done%0d", rep), 32'(bbus.done), 32'd1);
      chk($sformatf("big.rand_model%0d", rep), bbus.signature, 32'(m));
      if (rep == 0) sig_a = bbus.signature;
      else chk("big.repeat", bbus.signature, sig_a);
    end

    // randomized traffic on the small instance against the reference model
    rst = 1'b1;
    #3 rst = 1'b0;
    m_mode = 0; m_sig = 8'h00; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 11) == 0);
      sd = 8'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      if (st) begin
        m_mode = 1; m_sig = sd; m_cnt = 0;
      end else if (m_mode == 1 && v) begin
        m_sig = 8'(ref_step(64'(m_sig), 64'(d), 8, 64'h1D));
        m_cnt++;
        if (m_cnt == 3) m_mode = 2;
      end
      ex = $urandom_range(0, 1) ? m_sig : 8'($urandom);
      s_drive(st, sd, v, d, ex);
      tick();
      s_check($sformatf("rand%0d", i), m_sig, m_cnt, m_mode == 1, m_mode == 2,
              (m_mode == 2) && (m_sig == ex));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
